sr_latch_bank: RTL

//  Clocked, debounced bank of set/reset flip-flops. Each channel has its own
//  S/R command inputs, a stability filter and programmable S&R priority.
//  q/qbar replace free-running cross-coupled NOR latches.

---
 rtl/sr_latch_bank_pkg.sv | 29 ++
 rtl/sr_channel.sv | 129 ++++++++++++
 rtl/sr_latch_bank.sv | 61 ++++++
 3 files changed

// File: rtl/sr_latch_bank_pkg.sv
// ---------------------------------------------------------------------------
// sr_bank_defs
//   Shared definitions for the debounced S/R flip-flop bank.
//   - cmd_t  : per-channel command encoding, built as {r, s}
//   - clog2  : elaboration-time ceiling log2, used to size the run counters
// ---------------------------------------------------------------------------
package sr_bank_defs;

    typedef enum logic [1:0] {
        CMD_HOLD = 2'b00,
        CMD_SET  = 2'b01,
        CMD_RST  = 2'b10,
        CMD_BOTH = 2'b11
    } cmd_t;

    // Ceiling log2, never smaller than 1 so a counter always has a bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/sr_channel.sv
// ---------------------------------------------------------------------------
// sr_channel
//   One channel of the S/R bank: stability filter on {r, s}, the q flop and
//   the q edge pulses.
//   Optional feature macro: SRBANK_CONFLICT_EN adds the sticky conflict output.
// Ports
//   clk       in  rising-edge clock
//   reset     in  synchronous, active-high (priority over clr)
//   clr       in  synchronous channel clear, same effect as reset
//   s, r      in  set / reset requests
//   q, qbar   out registered state and its inverse
//   q_rise    out 1-cycle pulse registered with a q 0->1 change
//   q_fall    out 1-cycle pulse registered with a q 1->0 change
//   conflict  out sticky flag, set when a BOTH command is applied
// ---------------------------------------------------------------------------
module sr_channel
    import sr_bank_defs::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit SET_DOMINANT    = 1'b1,
    parameter bit RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic s,
    input  logic r,
    output logic q,
    output logic qbar,
    output logic q_rise,
    output logic q_fall
`ifdef SRBANK_CONFLICT_EN
    ,
    output logic conflict
`endif
);

    localparam int               CNT_W   = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    cmd_t             cmd;
    cmd_t             cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] run;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             apply;
    logic             apply_val;
`ifdef SRBANK_CONFLICT_EN
    logic             conflict_q, conflict_d;
`endif

    always_comb begin
        cmd = cmd_t'({r, s});

        // Length of the current run of identical samples, saturating at D.
        if (cmd == cand_q) begin
            run = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 1'b1;
        end else begin
            run = CNT_W'(1);
        end

        // Fire once when the run first reaches D. A new command always counts
        // as a fresh run, which keeps D=1 acting on every command change even
        // though the previous run had also saturated at 1.
        apply = (run == CNT_MAX) && (cmd != CMD_HOLD) &&
                ((cmd != cand_q) || (cnt_q != CNT_MAX));

        unique case (cmd)
            CMD_SET:  apply_val = 1'b1;
            CMD_RST:  apply_val = 1'b0;
            CMD_BOTH: apply_val = SET_DOMINANT;
            default:  apply_val = q_q;
        endcase

        cand_d = cmd;
        cnt_d  = run;
        q_d    = apply ? apply_val : q_q;
        rise_d = apply &  apply_val & ~q_q;
        fall_d = apply & ~apply_val &  q_q;
`ifdef SRBANK_CONFLICT_EN
        conflict_d = conflict_q | (apply && (cmd == CMD_BOTH));
`endif

        // clr discards any run in progress and wins over a same-cycle apply.
        if (clr) begin
            cand_d = CMD_HOLD;
            cnt_d  = '0;
            q_d    = RESET_VAL;
            rise_d = 1'b0;
            fall_d = 1'b0;
`ifdef SRBANK_CONFLICT_EN
            conflict_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cand_q <= CMD_HOLD;
            cnt_q  <= '0;
            q_q    <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
`ifdef SRBANK_CONFLICT_EN
            conflict_q <= 1'b0;
`endif
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            q_q    <= q_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
`ifdef SRBANK_CONFLICT_EN
            conflict_q <= conflict_d;
`endif
        end
    end

    assign q      = q_q;
    assign qbar   = ~q_q;
    assign q_rise = rise_q;
    assign q_fall = fall_q;
`ifdef SRBANK_CONFLICT_EN
    assign conflict = conflict_q;
`endif

endmodule

// File: rtl/sr_latch_bank.sv
// ---------------------------------------------------------------------------
// sr_latch_bank
//   Clocked, debounced bank of independent set/reset flip-flops replacing
//   cross-coupled NOR latches between the input stage and downstream FSMs.
//   Optional feature macro: SRBANK_CONFLICT_EN adds the conflict port.
// Ports
//   clk       in  1         rising-edge clock
//   reset     in  1         synchronous, active-high
//   clr       in  1         synchronous bank clear
//   s, r      in  CHANNELS  per-channel set / reset requests
//   q, qbar   out CHANNELS  registered state and its inverse
//   q_rise    out CHANNELS  1-cycle pulses on q 0->1
//   q_fall    out CHANNELS  1-cycle pulses on q 1->0
//   conflict  out CHANNELS  sticky S&R flags (SRBANK_CONFLICT_EN only)
// ---------------------------------------------------------------------------
module sr_latch_bank
    import sr_bank_defs::*;
#(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter bit SET_DOMINANT    = 1'b1,
    parameter bit RESET_VAL       = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic [CHANNELS-1:0] s,
    input  logic [CHANNELS-1:0] r,
    output logic [CHANNELS-1:0] q,
    output logic [CHANNELS-1:0] qbar,
    output logic [CHANNELS-1:0] q_rise,
    output logic [CHANNELS-1:0] q_fall
`ifdef SRBANK_CONFLICT_EN
    ,
    output logic [CHANNELS-1:0] conflict
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        sr_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SET_DOMINANT   (SET_DOMINANT),
            .RESET_VAL      (RESET_VAL)
        ) u_ch (
            .clk     (clk),
            .reset   (reset),
            .clr     (clr),
            .s       (s[i]),
            .r       (r[i]),
            .q       (q[i]),
            .qbar    (qbar[i]),
            .q_rise  (q_rise[i]),
            .q_fall  (q_fall[i])
`ifdef SRBANK_CONFLICT_EN
            ,
            .conflict(conflict[i])
`endif
        );
    end

endmodule
